// File: rtl/ripple_carry_adder_pkg.sv
// rtl/ripple_carry_adder_pkg.sv - shared constants for the ripple-carry adder
package ripple_carry_adder_pkg;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/ripple_carry_adder_full_adder.sv
// rtl/ripple_carry_adder_full_adder.sv - single-bit full adder cell of the ripple chain
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic w_prop;

  assign w_prop = a ^ b;
  assign s      = w_prop ^ cin;
  assign cout   = (a & b) | (cin & w_prop);

endmodule

// File: rtl/ripple_carry_adder.sv
// rtl/ripple_carry_adder.sv - combinational ripple-carry adder with a registered result stage
module ripple_carry_adder
  import ripple_carry_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  output logic [WIDTH-1:0] S,
  output logic [WIDTH:1]   C,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic [WIDTH-1:0] S_r,
  output logic             C_out_r,
  output logic             ovf_r,
  output logic             out_valid
);

  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_valid;

  assign w_carry[0] = C_in;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      full_adder u_fa (
        .a    (A[gi]),
        .b    (B[gi]),
        .cin  (w_carry[gi]),
        .s    (S[gi]),
        .cout (w_carry[gi+1])
      );
    end
  endgenerate

  assign C = w_carry[WIDTH:1];

  // Signed overflow: carry into the sign bit differs from carry out of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_sum  <= S;
        r_cout <= w_carry[WIDTH];
        r_ovf  <= w_carry[WIDTH] ^ w_carry[WIDTH-1];
      end
    end
  end

  assign S_r       = r_sum;
  assign C_out_r   = r_cout;
  assign ovf_r     = r_ovf;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_ripple_carry_adder.sv
// tb/tb_ripple_carry_adder.sv - directed self-checking bench for ripple_carry_adder
module tb_ripple_carry_adder;

  logic [3:0] S;
  logic [4:1] C;
  logic [3:0] A;
  logic [3:0] B;
  logic       C_in;
  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] S_r;
  logic       C_out_r;
  logic       ovf_r;
  logic       out_valid;

  int n_tests = 0;
  int n_fail  = 0;

  ripple_carry_adder #(.WIDTH(4)) dut (
    .S         (S),
    .C         (C),
    .A         (A),
    .B         (B),
    .C_in      (C_in),
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .S_r       (S_r),
    .C_out_r   (C_out_r),
    .ovf_r     (ovf_r),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic ci, input logic v);
    A = a; B = b; C_in = ci; in_valid = v;
  endtask

  task automatic load(input logic [3:0] a, input logic [3:0] b, input logic ci);
    @(negedge clk);
    drive(a, b, ci, 1'b1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] v;
    logic [3:0] hold_s;
    rst_n = 1'b0;
    drive(4'd0, 4'd0, 1'b0, 1'b0);
    #1;
    chk("rst_S_r", S_r, 0);
    chk("rst_C_out_r", C_out_r, 0);
    chk("rst_ovf_r", ovf_r, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_comb_S", S, 0);
    #11;
    rst_n = 1'b1;

    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      v = i[7:0];
      drive(v[7:4], v[3:0], 1'b0, 1'b0);
      #1;
      chk("sweep_sum", {C[4], S}, {28'd0, v[7:4]} + {28'd0, v[3:0]});
      #9;
    end

    load(4'd5, 4'd3, 1'b0);
    chk("5p3_S", S, 4'b1000);
    chk("5p3_C", C, 4'b0111);
    chk("5p3_S_r", S_r, 4'b1000);
    chk("5p3_C_out_r", C_out_r, 0);
    chk("5p3_ovf_r", ovf_r, 1);
    chk("5p3_out_valid", out_valid, 1);

    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(4'(k + 9), 4'(k + 6), k[0], 1'b0);
      @(posedge clk);
      #1;
      chk("hold_S_r", S_r, 4'b1000);
      chk("hold_C_out_r", C_out_r, 0);
      chk("hold_ovf_r", ovf_r, 1);
      chk("hold_out_valid", out_valid, 0);
    end

    load(4'd15, 4'd1, 1'b0);
    chk("15p1_S", S, 4'b0000);
    chk("15p1_C", C, 4'b1111);
    chk("15p1_S_r", S_r, 4'b0000);
    chk("15p1_C_out_r", C_out_r, 1);
    chk("15p1_ovf_r", ovf_r, 0);

    load(4'd15, 4'd0, 1'b1);
    chk("15p0c_S", S, 4'b0000);
    chk("15p0c_C", C, 4'b1111);
    chk("15p0c_C_out_r", C_out_r, 1);

    load(4'd15, 4'd15, 1'b1);
    chk("allones_S", S, 4'b1111);
    chk("allones_C", C, 4'b1111);
    chk("allones_S_r", S_r, 4'b1111);
    chk("allones_C_out_r", C_out_r, 1);
    chk("allones_ovf_r", ovf_r, 0);

    load(4'd12, 4'd7, 1'b0);
    chk("wrap_S", S, 4'b0011);
    chk("wrap_S_r", S_r, 4'b0011);
    chk("wrap_C_out_r", C_out_r, 1);
    chk("wrap_ovf_r", ovf_r, 0);

    load(4'd8, 4'd8, 1'b0);
    chk("negovf_S_r", S_r, 4'b0000);
    chk("negovf_C_out_r", C_out_r, 1);
    chk("negovf_ovf_r", ovf_r, 1);

    load(4'd0, 4'd0, 1'b0);
    chk("zero_S", S, 4'b0000);
    chk("zero_C", C, 4'b0000);
    chk("zero_C_out_r", C_out_r, 0);
    chk("zero_ovf_r", ovf_r, 0);

    load(4'd7, 4'd7, 1'b0);
    chk("7p7_S", S, 4'b1110);
    chk("7p7_C", C, 4'b0111);
    chk("7p7_S_r", S_r, 4'b1110);
    chk("7p7_ovf_r", ovf_r, 1);
    chk("7p7_out_valid", out_valid, 1);

    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_S_r", S_r, 0);
    chk("midrst_C_out_r", C_out_r, 0);
    chk("midrst_ovf_r", ovf_r, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_S", S, 4'b1110);
    chk("midrst_C", C, 4'b0111);
    @(posedge clk);
    #1;
    chk("rsthold_S_r", S_r, 0);
    chk("rsthold_out_valid", out_valid, 0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    hold_s = S_r;
    chk("release_S_r", hold_s, 4'b1110);
    chk("release_out_valid", out_valid, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
